// File: rtl/i2c_target_regs_if.sv
// Byte-wide register-file port between the I2C target and the register storage.
// The target is the master of this port; the register file is the slave.
interface i2c_target_regs_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C register target: oversampled SCL/SDA decode, address match, pointer + data, auto-increment.
// Optional glitch filter on SCL/SDA enabled by defining I2C_GLITCH_FILTER_EN (uses FILTER_LEN).
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h39
`ifdef I2C_GLITCH_FILTER_EN
  , parameter int unsigned FILTER_LEN = 3
`endif
) (
  input  logic                    clk50,
  input  logic                    reset_n,
  input  logic                    SCL,
  inout  wire                     SDA,
  output logic                    busy,
  i2c_target_regs_if.master       regs
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PH_W   = 2;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK_W,
    ADDR_ACK_R,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bitcnt, bitcnt_n;
  logic [BYTE_W-1:0]   shreg, shreg_n;
  logic [PH_W-1:0]     phase, phase_n;
  logic                sda_oe, sda_oe_n;
  logic [BYTE_W-1:0]   ptr, ptr_n;
  logic                wr_en_q, wr_en_n;
  logic [BYTE_W-1:0]   wr_addr_q, wr_addr_n;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_n;
  logic                busy_n;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_p, sda_p;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  // Open-drain data pin: only ever pulled low.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]        filt;
  logic [1:0]        raw;
  logic [FCNT_W-1:0] fcnt [2];

  assign raw = {scl_sync[1], sda_sync[1]};

  // Filtered level follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign scl_f = filt[1];
  assign sda_f = filt[0];
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;

  // State and datapath registers.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      phase     <= '0;
      sda_oe    <= 1'b0;
      ptr       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      phase     <= phase_n;
      sda_oe    <= sda_oe_n;
      ptr       <= ptr_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      busy      <= busy_n;
    end
  end

  // Next-state and datapath logic; STOP beats START beats everything else.
  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    phase_n   = phase;
    sda_oe_n  = sda_oe;
    ptr_n     = ptr;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    if (wr_en_q) ptr_n = ptr + 8'd1;

    if (stop_ev) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      bitcnt_n = '0;
      phase_n  = '0;
    end else if (start_ev) begin
      state_n  = ADDR;
      sda_oe_n = 1'b0;
      bitcnt_n = '0;
      phase_n  = '0;
    end else begin
      unique case (state)
        IDLE: ;

        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_f};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              phase_n = '0;
              if (state == ADDR) begin
                if (shreg[6:0] == SLAVE_ADDR) state_n = sda_f ? ADDR_ACK_R : ADDR_ACK_W;
                else                          state_n = IGNORE;
              end else if (state == REG) begin
                state_n = REG_ACK;
              end else begin
                state_n   = WDATA_ACK;
                wr_en_n   = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = {shreg[6:0], sda_f};
              end
            end
          end
        end

        // ACK slot: pull low from the fall ending bit 8 to the fall ending bit 9.
        ADDR_ACK_W, ADDR_ACK_R, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (phase == 2'd0) begin
              phase_n  = 2'd1;
              sda_oe_n = 1'b1;
            end else begin
              phase_n  = '0;
              sda_oe_n = 1'b0;
              bitcnt_n = '0;
              if (state == ADDR_ACK_R) begin
                state_n  = RDATA;
                shreg_n  = regs.rd_data;
                sda_oe_n = ~regs.rd_data[7];
              end else if (state == REG_ACK) begin
                state_n = WDATA;
                ptr_n   = shreg;
              end else begin
                state_n = (state == ADDR_ACK_W) ? REG : WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state_n = RACK;
              phase_n = '0;
            end
          end else if (scl_fall) begin
            shreg_n  = {shreg[6:0], 1'b0};
            sda_oe_n = ~shreg[6];
          end
        end

        // Release, sample the master's ACK/NACK, then relaunch on the next fall.
        RACK: begin
          unique case (phase)
            2'd0: if (scl_fall) begin
              sda_oe_n = 1'b0;
              phase_n  = 2'd1;
            end
            2'd1: if (scl_rise) begin
              if (sda_f) begin
                state_n = IGNORE;
                phase_n = '0;
              end else begin
                ptr_n   = ptr + 8'd1;
                phase_n = 2'd2;
              end
            end
            default: if (scl_fall) begin
              state_n  = RDATA;
              shreg_n  = regs.rd_data;
              sda_oe_n = ~regs.rd_data[7];
              bitcnt_n = '0;
              phase_n  = '0;
            end
          endcase
        end

        IGNORE: sda_oe_n = 1'b0;

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  assign regs.wr_en   = wr_en_q;
  assign regs.wr_addr = wr_addr_q;
  assign regs.wr_data = wr_data_q;
  assign regs.rd_addr = ptr;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a transaction-level pointer/register model.
module tb_i2c_target_regs;
  localparam int unsigned HALF = 8;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic reset_n;
  logic m_scl;
  logic m_sda_low;
  logic busy;
  wire  SDA;

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_regs_if rif ();
  assign rif.rd_data = rif.rd_addr + 8'd1;

  i2c_target_regs dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .SCL     (m_scl),
    .SDA     (SDA),
    .busy    (busy),
    .regs    (rif)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  wr_t        wr_obs[$];
  int         wr_double = 0;
  logic       wr_prev = 1'b0;
  logic [7:0] model_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every write strobe and flag strobes longer than one cycle.
  always @(negedge clk50) begin
    if (rif.wr_en === 1'b1) begin
      wr_obs.push_back({rif.wr_addr, rif.wr_data});
      if (wr_prev) wr_double <= wr_double + 1;
    end
    wr_prev <= (rif.wr_en === 1'b1);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; cyc(HALF);
    m_scl = 1'b1;     cyc(HALF);
    m_sda_low = 1'b1; cyc(HALF);
    m_scl = 1'b0;     cyc(4);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; cyc(HALF);
    m_scl = 1'b1;     cyc(HALF);
    m_sda_low = 1'b0; cyc(HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda_low = ~b[7-i]; cyc(HALF);
      m_scl = 1'b1;        cyc(HALF);
      m_scl = 1'b0;        cyc(4);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda_low = 1'b0; cyc(HALF);
    m_scl = 1'b1;     cyc(HALF/2);
    ack = (SDA === 1'b0);
    cyc(HALF/2);
    m_scl = 1'b0;     cyc(4);
  endtask

  task automatic read_byte(output logic [7:0] b, input bit nack);
    b = 8'h00;
    m_sda_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(HALF);
      m_scl = 1'b1; cyc(HALF/2);
      b[7-i] = (SDA !== 1'b0);
      cyc(HALF/2);
      m_scl = 1'b0; cyc(4);
    end
    m_sda_low = ~nack; cyc(HALF);
    m_scl = 1'b1;      cyc(HALF);
    m_scl = 1'b0;      cyc(4);
    m_sda_low = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] abyte, input logic [7:0] rg, input int n,
                          input logic [31:0] dpack, input bit no_stop, input string tag);
    logic ack;
    bit   match;
    int   base;
    wr_t  exp_q[$];
    match = (abyte == 8'h72);
    base  = wr_obs.size();
    i2c_start();
    write_byte(abyte, ack); check({tag, ".aack"}, 32'(ack), 32'(match));
    write_byte(rg, ack);    check({tag, ".rack"}, 32'(ack), 32'(match));
    if (match) model_ptr = rg;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = dpack[8*i +: 8];
      write_byte(d, ack); check({tag, ".dack"}, 32'(ack), 32'(match));
      if (match) begin
        exp_q.push_back({model_ptr, d});
        model_ptr = model_ptr + 8'd1;
      end
    end
    if (!no_stop) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      i2c_stop(); cyc(4);
      check({tag, ".idle"}, 32'(busy), 32'd0);
    end
    cyc(2);
    check({tag, ".nwr"}, 32'(wr_obs.size() - base), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (base + i < wr_obs.size()) check({tag, ".wr"}, 32'(wr_obs[base+i]), 32'(exp_q[i]));
    check({tag, ".ptr"}, 32'(rif.rd_addr), 32'(model_ptr));
  endtask

  task automatic do_read(input int n, input string tag);
    logic       ack;
    logic [7:0] b;
    int         base;
    base = wr_obs.size();
    i2c_start();
    write_byte(8'h73, ack); check({tag, ".aack"}, 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i == n - 1));
      check({tag, ".byte"}, 32'(b), 32'(model_ptr + 8'd1));
      if (i != n - 1) model_ptr = model_ptr + 8'd1;
    end
    cyc(4);
    check({tag, ".rel"}, 32'(SDA === 1'b1), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    i2c_stop(); cyc(4);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".nowr"}, 32'(wr_obs.size() - base), 32'd0);
    check({tag, ".ptr"}, 32'(rif.rd_addr), 32'(model_ptr));
  endtask

  initial begin
    logic ack;
    int   base;
    int   kind;
    bit   seen;
    bit   exp_seen;
    logic [6:0] a7;

    reset_n   = 1'b0;
    m_scl     = 1'b1;
    m_sda_low = 1'b0;
    model_ptr = 8'h00;
    cyc(5);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.wr_en", 32'(rif.wr_en), 32'd0);
    check("rst.wr_addr", 32'(rif.wr_addr), 32'd0);
    check("rst.wr_data", 32'(rif.wr_data), 32'd0);
    check("rst.rd_addr", 32'(rif.rd_addr), 32'd0);
    check("rst.sda", 32'(SDA === 1'b1), 32'd1);
    reset_n = 1'b1;
    cyc(10);

    do_write(8'h72, 8'h41, 1, 32'h0000_0010, 1'b0, "w1");
    do_write(8'h74, 8'h41, 1, 32'h0000_0010, 1'b0, "wbad");
    do_write(8'h72, 8'hFE, 3, 32'h00A3_A2A1, 1'b0, "wrap");
    do_write(8'h72, 8'h98, 0, 32'h0, 1'b1, "rptr");
    do_read(2, "rd2");

    // Stop in the middle of a data byte.
    base = wr_obs.size();
    i2c_start();
    write_byte(8'h72, ack); check("part.aack", 32'(ack), 32'd1);
    write_byte(8'h20, ack); check("part.rack", 32'(ack), 32'd1);
    model_ptr = 8'h20;
    send_bits(8'hC5, 4);
    i2c_stop(); cyc(4);
    check("part.idle", 32'(busy), 32'd0);
    check("part.nowr", 32'(wr_obs.size() - base), 32'd0);
    check("part.ptr", 32'(rif.rd_addr), 32'(model_ptr));

    for (int t = 0; t < 12; t++) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        0: do_write(8'h72, 8'($urandom), int'($urandom_range(1, 4)), $urandom, 1'b0, "rnd.w");
        1: begin
          if ($urandom_range(0, 1) == 1) do_write(8'h72, 8'($urandom), 0, 32'h0, 1'b1, "rnd.p");
          do_read(int'($urandom_range(1, 3)), "rnd.r");
        end
        default: begin
          do a7 = 7'($urandom_range(0, 127)); while (a7 == 7'h39);
          do_write({a7, 1'b0}, 8'($urandom), int'($urandom_range(1, 2)), $urandom, 1'b0, "rnd.x");
        end
      endcase
    end

    // Asynchronous reset while the target is holding an ACK.
    i2c_start();
    send_bits(8'h72, 8);
    m_sda_low = 1'b0; cyc(HALF);
    m_scl = 1'b1;     cyc(HALF/2);
    check("arst.drv", 32'(SDA === 1'b0), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst.sda", 32'(SDA === 1'b1), 32'd1);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.wr_en", 32'(rif.wr_en), 32'd0);
    check("arst.wr_addr", 32'(rif.wr_addr), 32'd0);
    check("arst.wr_data", 32'(rif.wr_data), 32'd0);
    check("arst.rd_addr", 32'(rif.rd_addr), 32'd0);
    model_ptr = 8'h00;
    cyc(4);
    reset_n = 1'b1;
    cyc(10);
    do_read(1, "post_rst");

    // Two-cycle SDA low pulse with SCL high.
`ifdef I2C_GLITCH_FILTER_EN
    exp_seen = 1'b0;
`else
    exp_seen = 1'b1;
`endif
    base = wr_obs.size();
    seen = 1'b0;
    cyc(10);
    m_sda_low = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk50);
      if (busy) seen = 1'b1;
    end
    m_sda_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk50);
      if (busy) seen = 1'b1;
    end
    check("glitch.seen", 32'(seen), 32'(exp_seen));
    check("glitch.idle", 32'(busy), 32'd0);
    check("glitch.nowr", 32'(wr_obs.size() - base), 32'd0);

    check("wr_single", 32'(wr_double), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) that sits at the far end of the team's I2C configuration master, the one that writes HDMI transmitter registers.
- Used as an on-chip register slave, and as a bus-functional responder for the config master.
- Oversamples SCL/SDA on clk50, decodes START/STOP/address/register-pointer/data, ACKs matching transactions, and drives a byte-wide register-file port.
- Supports writes and reads, with pointer auto-increment.

Parameters:
- SLAVE_ADDR, 7'h39: 7-bit target address. Write byte 0x72, read byte 0x73.
- FILTER_LEN, 3: consecutive identical samples required by the glitch filter (only used with the optional feature).

Ports:
- clk50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from the master.
- SDA  inout  1  I2C data. Driven only 1'b0 or 1'bz; never driven high.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  8  register pointer for the write.
- wr_data  output  8  received data byte.
- rd_addr  output  8  current register pointer, for reads.
- rd_data  input  8  register contents at rd_addr. Combinational source.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: all outputs 0 (wr_en, wr_addr, wr_data, rd_addr, busy). SDA = z. State = IDLE. Pointer = 0x00.
- Asynchronous reset mid-transfer releases SDA in the same cycle.
- Input path: 2-flop synchroniser on SCL and SDA, then a previous-sample register.
  - Edge and START/STOP events are visible 3 clk50 cycles after the pin changes.
- Events:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - STOP takes priority if both are detected in the same cycle (not possible with a stable SCL).
- Data bits are sampled on SCL rising. SDA drive changes only on SCL falling.
- bitcnt is 3 bits and is cleared on START and on entry to each byte state.
- States:
  - IDLE:
    - START -> ADDR.
    - Everything else ignored.
  - ADDR:
    - Shift 8 bits, MSB first.
    - After the 8th rise: if byte[7:1]==SLAVE_ADDR, then R/W=0 -> ADDR_ACK_W, R/W=1 -> ADDR_ACK_R.
    - Otherwise -> IGNORE.
  - ADDR_ACK_W / ADDR_ACK_R:
    - Drive SDA low from the next SCL fall until the following SCL fall.
    - Then go to REG (W) or RDATA (R).
    - Entering RDATA latches rd_data into the shift register at that fall.
  - REG:
    - 8 bits -> ACK, then pointer = byte -> WDATA.
  - WDATA:
    - 8 bits -> ACK.
    - At the 8th rise + 1 cycle: wr_en=1 for one cycle, wr_addr=pointer, wr_data=byte.
    - Pointer increments in the cycle after wr_en, wrapping 0xFF->0x00.
    - After the ACK, remain in WDATA.
  - RDATA:
    - Drive the shift-register MSB on each SCL fall (0 -> low, 1 -> z).
    - After the 8th bit, release SDA -> RACK.
  - RACK:
    - Sample SDA on SCL rise.
    - 0 (ACK): pointer++, latch rd_data at the next fall -> RDATA.
    - 1 (NACK): -> IGNORE.
  - IGNORE:
    - SDA released.
    - Wait for STOP or START.
- STOP in any state -> IDLE, SDA released.
  - A partial byte is discarded; no wr_en.
- START in any non-IDLE state (repeated start) -> ADDR. The pointer is preserved.
- busy = (state != IDLE), registered.
- Minimum SCL high/low: 6 clk50 cycles. 400 kHz SCL is well within this.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after the synchroniser, SCL and SDA each pass through a filter. The filtered value changes only after FILTER_LEN consecutive equal samples.
  - Event latency becomes 3+FILTER_LEN cycles.
  - Pulses of FILTER_LEN-1 cycles or shorter are suppressed.
- Undefined: no filter, 3-cycle latency, and every synchronised transition is honoured.

Test Plan:
- Write 0x72, 0x41, 0x10, STOP -> three ACKs (SDA low during the 9th SCL high); wr_en single pulse with wr_addr=0x41, wr_data=0x10; busy falls after STOP.
- Write 0x74, 0x41, 0x10 -> no ACK (SDA=z on the 9th clock), no wr_en, state IGNORE until STOP.
- Write 0x72, 0xFE, 0xA1, 0xA2, 0xA3 -> wr_en at addresses 0xFE, 0xFF, 0x00 with data A1/A2/A3 (pointer wraps).
- Write 0x72, 0x98; repeated START; 0x73; rd_data model = addr+1 -> master reads 0x99 (ACK) then 0x9A (NACK); no SDA drive after NACK; STOP -> IDLE.
- STOP after 4 bits of a data byte -> IDLE, no wr_en. Then reset_n low while driving an ACK -> SDA=z and all outputs 0 immediately.
- With I2C_GLITCH_FILTER_EN and FILTER_LEN=3: 2-cycle SDA low glitch while SCL is high -> no START detected. Without the macro, the same glitch -> START then STOP detected, busy returns to 0.
